int32_to_fp32: RTL and testbench



---
 rtl/int32_to_fp32.sv | 155 +++++++++++++++
 tb/tb_int32_to_fp32.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/int32_to_fp32.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : int32_to_fp32
// Brief    : Signed int32 to IEEE-754 fp32 converter (round to nearest even),
//            strobe/acknowledge handshake on both sides, one shift per cycle.
// Revision : 1.0  initial release
// ============================================================================
module int32_to_fp32 (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [2:0] {
        S_GET_A     = 3'd0,
        S_CONVERT_0 = 3'd1,
        S_CONVERT_1 = 3'd2,
        S_CONVERT_2 = 3'd3,
        S_ROUND     = 3'd4,
        S_PACK      = 3'd5,
        S_PUT_Z     = 3'd6
    } state_t;

    localparam logic [7:0] c_EXP_BIAS = 8'd127;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_a;
    logic [31:0] r_value;
    logic [7:0]  r_z_e;
    logic [23:0] r_z_m;
    logic        r_sign;
    logic        r_guard;
    logic        r_round_bit;
    logic        r_sticky;
    logic [31:0] r_z;
    logic        r_input_a_ack;
    logic        r_output_z_stb;
    logic [31:0] r_output_z;

    logic        w_a_xfer;
    logic        w_z_xfer;
    logic [31:0] w_abs;
    logic        w_round_up;
    logic [7:0]  w_exp_field;

    assign w_a_xfer    = r_input_a_ack & input_a_stb;
    assign w_z_xfer    = r_output_z_stb & output_z_ack;
    // 0x80000000 negates to itself, which is exactly the unsigned magnitude.
    assign w_abs       = r_a[31] ? (~r_a + 32'd1) : r_a;
    assign w_round_up  = r_guard & (r_round_bit | r_sticky | r_z_m[0]);
    assign w_exp_field = r_z_e + c_EXP_BIAS;

    assign input_a_ack  = r_input_a_ack;
    assign output_z     = r_output_z;
    assign output_z_stb = r_output_z_stb;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_GET_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_GET_A:     if (w_a_xfer) w_next_state = S_CONVERT_0;
            S_CONVERT_0: w_next_state = (r_a == 32'd0) ? S_PUT_Z : S_CONVERT_1;
            S_CONVERT_1: if (r_value[31]) w_next_state = S_CONVERT_2;
            S_CONVERT_2: w_next_state = S_ROUND;
            S_ROUND:     w_next_state = S_PACK;
            S_PACK:      w_next_state = S_PUT_Z;
            S_PUT_Z:     if (w_z_xfer) w_next_state = S_GET_A;
            default:     w_next_state = S_GET_A;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_input_a_ack  <= 1'b0;
            r_output_z_stb <= 1'b0;
            r_output_z     <= 32'd0;
            r_a            <= 32'd0;
            r_value        <= 32'd0;
            r_z_e          <= 8'd0;
            r_z_m          <= 24'd0;
            r_sign         <= 1'b0;
            r_guard        <= 1'b0;
            r_round_bit    <= 1'b0;
            r_sticky       <= 1'b0;
            r_z            <= 32'd0;
        end else begin
            case (r_state)
                S_GET_A: begin
                    r_input_a_ack <= 1'b1;
                    if (w_a_xfer) begin
                        r_a           <= input_a;
                        r_input_a_ack <= 1'b0;
                    end
                end
                S_CONVERT_0: begin
                    if (r_a == 32'd0) begin
                        r_z <= 32'd0;
                    end else begin
                        r_sign  <= r_a[31];
                        r_value <= w_abs;
                        r_z_e   <= 8'd31;
                    end
                end
                S_CONVERT_1: begin
                    if (!r_value[31]) begin
                        r_value <= {r_value[30:0], 1'b0};
                        r_z_e   <= r_z_e - 8'd1;
                    end
                end
                S_CONVERT_2: begin
                    r_z_m       <= r_value[31:8];
                    r_guard     <= r_value[7];
                    r_round_bit <= r_value[6];
                    r_sticky    <= |r_value[5:0];
                end
                S_ROUND: begin
                    // An all-ones mantissa wraps to zero; the carry moves into the exponent.
                    if (w_round_up) begin
                        r_z_m <= r_z_m + 24'd1;
                        if (&r_z_m) r_z_e <= r_z_e + 8'd1;
                    end
                end
                S_PACK: begin
                    r_z <= {r_sign, w_exp_field, r_z_m[22:0]};
                end
                S_PUT_Z: begin
                    r_output_z_stb <= 1'b1;
                    r_output_z     <= r_z;
                    if (w_z_xfer) r_output_z_stb <= 1'b0;
                end
                default: begin
                    r_input_a_ack  <= 1'b0;
                    r_output_z_stb <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int32_to_fp32.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_int32_to_fp32
// Brief    : Directed-vector bench for int32_to_fp32 plus a randomised pass
//            checked against an independent double-precision reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_int32_to_fp32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] input_a = 32'd0;
    logic        input_a_stb = 1'b0;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    int32_to_fp32 u_dut (
        .clock        (clock),
        .reset        (reset),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input logic [31:0] a);
        logic [31:0] mag;
        if (a == 32'd0) return 2;
        mag = a[31] ? (~a + 32'd1) : a;
        for (int i = 31; i >= 0; i--)
            if (mag[i]) return 6 + 31 - i;
        return 0;
    endfunction

    // Goes through an exact double, then rounds the 52-bit fraction down to 23.
    function automatic logic [31:0] ref_cvt(input logic [31:0] a);
        real         r;
        logic [63:0] d;
        logic [10:0] e;
        logic [52:0] m;
        logic [24:0] fm;
        logic [28:0] rem;
        logic [7:0]  fe;
        if (a == 32'd0) return 32'd0;
        r   = $itor($signed(a));
        d   = $realtobits(r);
        e   = d[62:52] - 11'd896;
        fe  = e[7:0];
        m   = {1'b1, d[51:0]};
        fm  = {1'b0, m[52:29]};
        rem = m[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && fm[0])) fm = fm + 25'd1;
        if (fm[24]) begin
            fe = fe + 8'd1;
            fm = 25'd0;
        end
        return {d[63], fe, fm[22:0]};
    endfunction

    task automatic convert(input string tag, input logic [31:0] a, input logic [31:0] exp_z,
                           input int hold, input int pre_stall);
        int          n;
        logic [31:0] held;
        repeat (pre_stall) @(negedge clock);
        @(negedge clock);
        input_a     = a;
        input_a_stb = 1'b1;
        n = 0;
        while (!input_a_ack && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!input_a_ack) begin
            check({tag, " in_ack_timeout"}, 32'(input_a_ack), 32'd1);
            input_a_stb = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        input_a_stb = 1'b0;
        input_a     = 32'hDEAD_BEEF;
        check({tag, " ack_drop"}, 32'(input_a_ack), 32'd0);
        n = 0;
        while (!output_z_stb && n < 60) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!output_z_stb) begin
            check({tag, " stb_timeout"}, 32'(output_z_stb), 32'd1);
            return;
        end
        check({tag, " latency"}, 32'(n), 32'(lat_of(a)));
        check({tag, " z"}, output_z, exp_z);
        held = output_z;
        repeat (hold) begin
            @(posedge clock);
            #1;
            check({tag, " hold_stb"}, 32'(output_z_stb), 32'd1);
            check({tag, " hold_z"}, output_z, held);
        end
        @(negedge clock);
        output_z_ack = 1'b1;
        @(posedge clock);
        #1;
        output_z_ack = 1'b0;
        check({tag, " stb_clear"}, 32'(output_z_stb), 32'd0);
        check({tag, " ack_gap"}, 32'(input_a_ack), 32'd0);
        @(posedge clock);
        #1;
        check({tag, " ack_back"}, 32'(input_a_ack), 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        int          k;

        #12;
        check("rst ack", 32'(input_a_ack), 32'd0);
        check("rst stb", 32'(output_z_stb), 32'd0);
        check("rst z", output_z, 32'd0);
        #10 reset = 1'b0;
        @(posedge clock);
        #1;
        check("first ack", 32'(input_a_ack), 32'd1);

        convert("zero",     32'd0,          32'h0000_0000, 0, 0);
        convert("one",      32'd1,          32'h3F80_0000, 0, 0);
        convert("minus1",   32'hFFFF_FFFF,  32'hBF80_0000, 0, 1);
        convert("min_int",  32'h8000_0000,  32'hCF00_0000, 0, 0);
        convert("max_int",  32'h7FFF_FFFF,  32'h4F00_0000, 0, 2);
        convert("tie_even", 32'd16777217,   32'h4B80_0000, 0, 0);
        convert("tie_up",   32'd16777219,   32'h4B80_0002, 0, 0);
        convert("neg_tie",  32'hFEFF_FFFB,  32'hCB80_0002, 0, 0);
        convert("three",    32'd3,          32'h4040_0000, 0, 0);
        convert("hundred",  32'd100,        32'h42C8_0000, 0, 0);
        convert("backpr",   32'd1000,       32'h447A_0000, 10, 0);
        convert("after_bp", 32'hFFFF_FF9C,  32'hC2C8_0000, 0, 0);

        // Abort a long conversion while it is still normalising.
        @(negedge clock);
        input_a     = 32'd1;
        input_a_stb = 1'b1;
        @(posedge clock);
        #1;
        input_a_stb = 1'b0;
        repeat (5) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("midrst ack", 32'(input_a_ack), 32'd0);
        check("midrst stb", 32'(output_z_stb), 32'd0);
        check("midrst z", output_z, 32'd0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        check("midrst ack_low", 32'(input_a_ack), 32'd0);
        @(posedge clock);
        #1;
        check("midrst ack_up", 32'(input_a_ack), 32'd1);
        convert("post_rst", 32'd5, 32'h40A0_0000, 0, 0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 2))
                0: v = $urandom;
                1: begin
                    k = $urandom_range(0, 31);
                    v = (32'd1 << k) + 32'($urandom_range(0, 2)) - 32'd1;
                    if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
                end
                default: v = 32'($urandom_range(0, 4095)) - 32'd2048;
            endcase
            convert("rand", v, ref_cvt(v), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
